// File: rtl/scalar_pkg.sv
// Shared types and default widths for the scalar core datapath.
`timescale 1ns/1ps
package scalar_pkg;

  // Default datapath and register-address widths, shared with the ALU.
  localparam int SCALAR_WIDTH      = 16;
  localparam int SCALAR_REG_ADDR_W = 4;

  // Occupancy of the two-entry EX/MEM skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // One buffered instruction travelling from execute to memory.
  typedef struct packed {
    logic [SCALAR_WIDTH-1:0]      result;
    logic [SCALAR_REG_ADDR_W-1:0] rd;
    logic                         reg_we;
    logic                         mem_we;
    logic                         mem_re;
    logic [SCALAR_WIDTH-1:0]      store_data;
  } ex_mem_entry_t;

endpackage

// File: rtl/scalar_ex_mem_reg.sv
// EX/MEM pipeline register: 2-entry skid buffer with valid/ready handshake,
// architectural Z/N flag register and youngest-first operand forwarding.
// The entry struct is sized by the package widths, so WIDTH/REG_ADDR_W
// must stay equal to the package defaults.
`timescale 1ns/1ps
module scalar_ex_mem_reg
  import scalar_pkg::*;
#(
  parameter int WIDTH      = SCALAR_WIDTH,
  parameter int REG_ADDR_W = SCALAR_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_result,
  input  logic                  in_flag_z,
  input  logic                  in_flag_n,
  input  logic                  in_set_flags,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_we,
  input  logic                  in_mem_we,
  input  logic                  in_mem_re,
  input  logic [WIDTH-1:0]      in_store_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_we,
  output logic                  out_mem_we,
  output logic                  out_mem_re,
  output logic [WIDTH-1:0]      out_store_data,
  output logic                  flag_z,
  output logic                  flag_n,
  input  logic [REG_ADDR_W-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [WIDTH-1:0]      fwd_data,
  output logic                  fwd_load_hazard
);

  buf_state_t    state_r;
  ex_mem_entry_t head_r;
  ex_mem_entry_t tail_r;
  logic          flag_z_r;
  logic          flag_n_r;

  ex_mem_entry_t in_entry_s;
  logic          accept_s;
  logic          drain_s;
  logic          head_valid_s;
  logic          tail_valid_s;

  // Handshake is a pure decode of registered state, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready     = (state_r != FULL);
  assign out_valid    = (state_r != EMPTY);
  assign head_valid_s = (state_r != EMPTY);
  assign tail_valid_s = (state_r == FULL);

  // Head entry registers drive the memory stage directly; they are kept
  // at zero whenever the buffer is empty.
  assign out_result     = head_r.result;
  assign out_rd         = head_r.rd;
  assign out_reg_we     = head_r.reg_we;
  assign out_mem_we     = head_r.mem_we;
  assign out_mem_re     = head_r.mem_re;
  assign out_store_data = head_r.store_data;
  assign flag_z         = flag_z_r;
  assign flag_n         = flag_n_r;

  // Pack the incoming instruction and qualify the two transfers.
  always_comb begin
    in_entry_s            = '0;
    in_entry_s.result     = in_result;
    in_entry_s.rd         = in_rd;
    in_entry_s.reg_we     = in_reg_we;
    in_entry_s.mem_we     = in_mem_we;
    in_entry_s.mem_re     = in_mem_re;
    in_entry_s.store_data = in_store_data;
    accept_s              = in_valid && in_ready;
    drain_s               = out_valid && out_ready;
  end

  // Buffer FSM, entry registers and flag register; flush beats any transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= EMPTY;
      head_r   <= '0;
      tail_r   <= '0;
      flag_z_r <= 1'b0;
      flag_n_r <= 1'b0;
    end else if (flush) begin
      // Flags keep their value: flush only discards in-flight entries.
      state_r <= EMPTY;
      head_r  <= '0;
      tail_r  <= '0;
    end else begin
      if (accept_s && in_set_flags) begin
        flag_z_r <= in_flag_z;
        flag_n_r <= in_flag_n;
      end
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            head_r  <= in_entry_s;
            state_r <= ONE;
          end
        end
        ONE: begin
          if (accept_s && !drain_s) begin
            tail_r  <= in_entry_s;
            state_r <= FULL;
          end else if (drain_s && !accept_s) begin
            head_r  <= '0;
            state_r <= EMPTY;
          end else if (accept_s && drain_s) begin
            head_r  <= in_entry_s;
          end
        end
        FULL: begin
          if (drain_s) begin
            head_r  <= tail_r;
            tail_r  <= '0;
            state_r <= ONE;
          end
        end
        default: begin
          state_r <= EMPTY;
          head_r  <= '0;
          tail_r  <= '0;
        end
      endcase
    end
  end

  // Forwarding lookup: tail is younger than head, so it is checked first;
  // a matching load cannot forward yet and raises the load-use hazard.
  always_comb begin
    fwd_hit         = 1'b0;
    fwd_data        = '0;
    fwd_load_hazard = 1'b0;
    if (tail_valid_s && tail_r.reg_we && (tail_r.rd == fwd_addr)) begin
      if (tail_r.mem_re) begin
        fwd_load_hazard = 1'b1;
      end else begin
        fwd_hit  = 1'b1;
        fwd_data = tail_r.result;
      end
    end else if (head_valid_s && head_r.reg_we && (head_r.rd == fwd_addr)) begin
      if (head_r.mem_re) begin
        fwd_load_hazard = 1'b1;
      end else begin
        fwd_hit  = 1'b1;
        fwd_data = head_r.result;
      end
    end else begin
      fwd_hit         = 1'b0;
      fwd_data        = '0;
      fwd_load_hazard = 1'b0;
    end
  end

endmodule

// File: tb/tb_scalar_ex_mem_reg.sv
// Directed self-checking bench for the EX/MEM skid buffer.
`timescale 1ns/1ps
module tb_scalar_ex_mem_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        in_flag_z;
  logic        in_flag_n;
  logic        in_set_flags;
  logic [3:0]  in_rd;
  logic        in_reg_we;
  logic        in_mem_we;
  logic        in_mem_re;
  logic [15:0] in_store_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_rd;
  logic        out_reg_we;
  logic        out_mem_we;
  logic        out_mem_re;
  logic [15:0] out_store_data;
  logic        flag_z;
  logic        flag_n;
  logic [3:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic        fwd_load_hazard;

  int n_checks;
  int n_fail;

  scalar_ex_mem_reg dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flag_z(in_flag_z), .in_flag_n(in_flag_n),
    .in_set_flags(in_set_flags), .in_rd(in_rd), .in_reg_we(in_reg_we),
    .in_mem_we(in_mem_we), .in_mem_re(in_mem_re), .in_store_data(in_store_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_reg_we(out_reg_we),
    .out_mem_we(out_mem_we), .out_mem_re(out_mem_re), .out_store_data(out_store_data),
    .flag_z(flag_z), .flag_n(flag_n),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .fwd_load_hazard(fwd_load_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction on the execute-side inputs.
  task automatic drive(input logic v, input logic [15:0] res, input logic [3:0] rd,
                       input logic rwe, input logic mre, input logic mwe,
                       input logic [15:0] sd, input logic z, input logic n,
                       input logic sf);
    in_valid      = v;
    in_result     = res;
    in_rd         = rd;
    in_reg_we     = rwe;
    in_mem_re     = mre;
    in_mem_we     = mwe;
    in_store_data = sd;
    in_flag_z     = z;
    in_flag_n     = n;
    in_set_flags  = sf;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; fwd_addr = 4'd0;
    idle();
    step(); step();
    rst_n = 1'b1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (out_result !== 16'h0000) begin n_fail++; $display("FAIL reset_out_result got %h exp 0000", out_result); end
    n_checks++; if ({flag_z, flag_n} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b%b exp 00", flag_z, flag_n); end
    n_checks++; if ({fwd_hit, fwd_load_hazard} !== 2'b00) begin n_fail++; $display("FAIL reset_fwd got %b%b exp 00", fwd_hit, fwd_load_hazard); end
  endtask

  task automatic test_stream();
    logic [15:0] vals [3];
    vals[0] = 16'h0005; vals[1] = 16'h0010; vals[2] = 16'hFFFF;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i], 4'(i + 1), 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); end
      step();
      n_checks++; if (out_valid !== 1'b1 || out_result !== vals[i]) begin
        n_fail++; $display("FAIL stream_out[%0d] got v=%b %h exp v=1 %h", i, out_valid, out_result, vals[i]);
      end
      n_checks++; if (out_rd !== 4'(i + 1)) begin n_fail++; $display("FAIL stream_rd[%0d] got %0d exp %0d", i, out_rd, i + 1); end
    end
    idle();
    step();
    n_checks++; if (out_valid !== 1'b0 || out_result !== 16'h0000) begin
      n_fail++; $display("FAIL stream_drained got v=%b %h exp v=0 0000", out_valid, out_result);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 16'h00A1, 4'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_one_ready got %b exp 1", in_ready); end
    drive(1'b1, 16'h00A2, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    drive(1'b1, 16'h00A3, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (out_result !== 16'h00A1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold got %h rdy=%b exp 00a1 rdy=0", out_result, in_ready);
    end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_result !== 16'h00A2 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain1 got %h rdy=%b exp 00a2 rdy=1", out_result, in_ready);
    end
    step();
    idle();
    n_checks++; if (out_result !== 16'h00A3 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain2 got %h v=%b exp 00a3 v=1", out_result, out_valid);
    end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    drive(1'b1, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    step();
    n_checks++; if ({flag_z, flag_n} !== 2'b10) begin n_fail++; $display("FAIL flags_set got %b%b exp 10", flag_z, flag_n); end
    drive(1'b1, 16'h8000, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    step();
    n_checks++; if ({flag_z, flag_n} !== 2'b10) begin n_fail++; $display("FAIL flags_hold got %b%b exp 10", flag_z, flag_n); end
    // Store with no register write is still buffered unmodified.
    drive(1'b1, 16'h0040, 4'd0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (out_mem_we !== 1'b1 || out_store_data !== 16'hBEEF || out_result !== 16'h0040 || out_reg_we !== 1'b0) begin
      n_fail++; $display("FAIL store_fields got we=%b sd=%h res=%h rwe=%b exp 1 beef 0040 0", out_mem_we, out_store_data, out_result, out_reg_we);
    end
    idle();
    step();
  endtask

  task automatic fill_two(input logic [3:0] rd0, input logic [15:0] r0, input logic mre0,
                          input logic [3:0] rd1, input logic [15:0] r1, input logic mre1);
    out_ready = 1'b0;
    drive(1'b1, r0, rd0, 1'b1, mre0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, r1, rd1, 1'b1, mre1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    idle();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_forward();
    fill_two(4'd3, 16'h1111, 1'b0, 4'd3, 16'h2222, 1'b0);
    fwd_addr = 4'd3; #1;
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h2222 || fwd_load_hazard !== 1'b0) begin
      n_fail++; $display("FAIL fwd_youngest got hit=%b %h hz=%b exp 1 2222 0", fwd_hit, fwd_data, fwd_load_hazard);
    end
    fwd_addr = 4'd4; #1;
    n_checks++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0000 || fwd_load_hazard !== 1'b0) begin
      n_fail++; $display("FAIL fwd_miss got hit=%b %h hz=%b exp 0 0000 0", fwd_hit, fwd_data, fwd_load_hazard);
    end
    do_flush();
    fill_two(4'd3, 16'h1111, 1'b0, 4'd3, 16'h2222, 1'b1);
    fwd_addr = 4'd3; #1;
    n_checks++; if (fwd_hit !== 1'b0 || fwd_load_hazard !== 1'b1) begin
      n_fail++; $display("FAIL fwd_load got hit=%b hz=%b exp 0 1", fwd_hit, fwd_load_hazard);
    end
    do_flush();
    fill_two(4'd3, 16'h1111, 1'b0, 4'd5, 16'h2222, 1'b0);
    fwd_addr = 4'd3; #1;
    n_checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h1111) begin
      n_fail++; $display("FAIL fwd_head got hit=%b %h exp 1 1111", fwd_hit, fwd_data);
    end
    do_flush();
    fwd_addr = 4'd0;
  endtask

  task automatic test_flush();
    fill_two(4'd1, 16'h0AAA, 1'b0, 4'd2, 16'h0BBB, 1'b0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_full got rdy=%b exp 0", in_ready); end
    drive(1'b1, 16'h0CCC, 4'd7, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 16'h0000) begin
      n_fail++; $display("FAIL flush_state got v=%b rdy=%b %h exp 0 1 0000", out_valid, in_ready, out_result);
    end
    n_checks++; if ({flag_z, flag_n} !== 2'b10) begin n_fail++; $display("FAIL flush_flags got %b%b exp 10", flag_z, flag_n); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard got v=%b %h exp 0", out_valid, out_result); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 16'h1234, 4'd9, 1'b1, 1'b1, 1'b1, 16'h5678, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (out_valid !== 1'b1 || out_result !== 16'h1234) begin
      n_fail++; $display("FAIL mid_pre got v=%b %h exp 1 1234", out_valid, out_result);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    n_checks++; if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_rd !== 4'd0 || out_reg_we !== 1'b0 ||
                    out_mem_we !== 1'b0 || out_mem_re !== 1'b0 || out_store_data !== 16'h0000) begin
      n_fail++; $display("FAIL mid_reset_out got v=%b %h rd=%0d %b%b%b sd=%h exp all 0", out_valid, out_result, out_rd,
                         out_reg_we, out_mem_we, out_mem_re, out_store_data);
    end
    n_checks++; if ({flag_z, flag_n} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_flags got %b%b exp 00", flag_z, flag_n); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_xfer got v=%b exp 0", out_valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flags();
    test_forward();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout simulation exceeded 100000ns");
    $fatal(1);
  end

endmodule

// File: doc/scalar_ex_mem_reg.md
Name: scalar_ex_mem_reg

Overview:
Pipeline register between the scalar ALU (execute) and the memory stage of the scalar core. It is a 2-entry skid buffer with valid/ready handshake that captures the ALU result, ALU flags and the instruction's control fields. It also holds the architectural Z/N flag register and provides a youngest-first operand-forwarding lookup, including load-use hazard detection, back to decode.

Parameters:
WIDTH, 16, datapath width; matches the ALU operand/result width
REG_ADDR_W, 4, register-file address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  execute stage presents an instruction
in_ready  out  1  buffer can accept this cycle
in_result  in  WIDTH  ALU result C
in_flag_z  in  1  ALU flagZ
in_flag_n  in  1  ALU flagN
in_set_flags  in  1  instruction updates architectural flags
in_rd  in  REG_ADDR_W  destination register
in_reg_we  in  1  instruction writes the register file
in_mem_we  in  1  store
in_mem_re  in  1  load (in_result is the address)
in_store_data  in  WIDTH  store data
flush  in  1  discard all buffered entries
out_valid  out  1  head entry valid toward memory stage
out_ready  in  1  memory stage accepts head
out_result, out_rd, out_reg_we, out_mem_we, out_mem_re, out_store_data  out  (as inputs)  head entry fields
flag_z  out  1  architectural zero flag
flag_n  out  1  architectural negative flag
fwd_addr  in  REG_ADDR_W  source register being looked up by decode
fwd_hit  out  1  buffered entry supplies fwd_addr
fwd_data  out  WIDTH  forwarded value
fwd_load_hazard  out  1  youngest match is a load; decode must stall

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to EMPTY; both entries are invalidated; flag_z=0 and flag_n=0.
  - All out_* fields are 0, out_valid=0, fwd_hit=0, fwd_load_hazard=0.
  - No transfer occurs in any cycle where rst_n=0. This includes reset asserted mid-stream: buffered entries are lost.
- Transfers:
  - Accept when in_valid && in_ready.
  - Drain when out_valid && out_ready.
- State machine:
  - EMPTY: accept -> ONE.
  - ONE:
    - accept && !drain -> FULL.
    - drain && !accept -> EMPTY.
    - accept && drain -> ONE, with the new entry becoming the head.
  - FULL:
    - drain -> ONE; the tail moves to the head on the same edge.
    - No accept is possible in FULL.
- Handshake outputs:
  - in_ready = (state != FULL). It is derived from registered state and does not depend combinationally on out_ready.
  - out_valid = (state != EMPTY).
- Latency: 1 cycle. An entry accepted at edge k is visible on out_* after edge k.
- Ordering and stability:
  - Order is strictly FIFO.
  - Head fields are stable while out_valid && !out_ready.
  - Payload is 0 when out_valid=0.
- Entry contents: every accepted entry is buffered, including ones with reg_we=mem_we=mem_re=0. There is no filtering.
- Flags:
  - On accept with in_set_flags=1, flag_z<=in_flag_z and flag_n<=in_flag_n.
  - Otherwise the flags hold.
  - Flags are not reverted by flush.
- Flush:
  - Flush has priority over accept and drain. The next state is EMPTY, in_ready=1 and out_valid=0.
  - An input presented in the flush cycle is discarded and does not update the flags.
- Forwarding (combinational on fwd_addr and the current entries):
  - Candidates are valid entries with reg_we=1 and rd==fwd_addr. The tail is checked before the head (youngest first).
  - If the youngest candidate has mem_re=0: fwd_hit=1, fwd_data=result, fwd_load_hazard=0.
  - If the youngest candidate has mem_re=1: fwd_hit=0, fwd_load_hazard=1.
  - No candidate: fwd_hit=0, fwd_load_hazard=0, fwd_data=0.
- Width rules: all fields are stored unmodified; there is no extension or truncation.

Decomposition:
- The package scalar_pkg contains:
  - the ex_mem_entry_t packed struct (result, rd, reg_we, mem_we, mem_re, store_data);
  - the buf_state_t enum {EMPTY, ONE, FULL};
  - the WIDTH/REG_ADDR_W defaults, shared with the ALU.
- No sub-module: the two entry registers, the state FSM, the flag register and the forwarding mux are all inline.

Test Plan:
- Reset, then stream 3 entries with out_ready=1 (results 0x0005, 0x0010, 0xFFFF) -> each appears 1 cycle after accept, in order; in_ready stays 1 throughout.
- Hold out_ready=0 and present 3 entries -> state FULL after 2 accepts; in_ready=0; the third is held upstream; raising out_ready drains the entries in order and accepts the third.
- Accept result 0x0000 with flag_z=1 and in_set_flags=1, then 0x8000 with flag_n=1 and in_set_flags=0 -> flag_z=1 and flag_n=0 afterwards.
- FULL with head rd=3 (result 0x1111) and tail rd=3 (result 0x2222), fwd_addr=3 -> fwd_hit=1 with fwd_data=0x2222; with tail mem_re=1 instead -> fwd_hit=0 and fwd_load_hazard=1.
- FULL, then assert flush together with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed input never appears and the flags are unchanged.
- Assert rst_n=0 for one edge while in state ONE with out_ready=0 -> out_valid=0, all out_* fields 0, flag_z=flag_n=0.
